// File: rtl/obs_force_bank.sv
// obs_force_bank: per-channel observe/force bank with change counters and a host handshake
module obs_force_bank #(
   parameter int NUM_CH = 4,
   parameter int WIDTH  = 8,
   parameter int CNT_W  = 16,
   localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [NUM_CH*WIDTH-1:0] dut_val_i,
   output logic [NUM_CH*WIDTH-1:0] obs_val_o,
   output logic [NUM_CH-1:0]       force_active_o,
   input  logic                    host_req_i,
   input  logic [1:0]              host_op_i,
   input  logic [CH_W-1:0]         host_ch_i,
   input  logic [WIDTH-1:0]        host_wdata_i,
   output logic                    host_ack_o,
   output logic [CNT_W-1:0]        host_rdata_o,
   output logic                    host_err_o
);
   typedef enum logic [1:0] {IDLE, EXEC, ACK, WAIT_LOW} state_t;
   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [CH_W-1:0]    ch_q, ch_d;
   logic [WIDTH-1:0]   wdata_q, wdata_d;
   logic [NUM_CH-1:0]  force_en_q, force_en_d;
   logic [WIDTH-1:0]   force_val_q [NUM_CH];
   logic [WIDTH-1:0]   force_val_d [NUM_CH];
   logic [WIDTH-1:0]   obs_q [NUM_CH];
   logic [WIDTH-1:0]   obs_d [NUM_CH];
   logic [CNT_W-1:0]   cnt_q [NUM_CH];
   logic [CNT_W-1:0]   cnt_d [NUM_CH];
   logic               ack_q, ack_d;
   logic [CNT_W-1:0]   rdata_q, rdata_d;
   logic               err_q, err_d;
   logic [NUM_CH-1:0]  chg;
   logic [NUM_CH-1:0]  sel;
   logic               exec;
   logic               ch_ok;
   genvar g;
   for (g = 0; g < NUM_CH; g++) begin : g_obs
      assign obs_val_o[g*WIDTH +: WIDTH] = obs_q[g];
   end
   assign force_active_o = force_en_q;
   assign host_ack_o     = ack_q;
   assign host_rdata_o   = rdata_q;
   assign host_err_o     = err_q;
   assign exec           = (state_q == EXEC);
   assign ch_ok          = int'(ch_q) < NUM_CH;
   // next-state: handshake sequencing, request latching, op execution, datapath and counters
   always_comb begin
      state_d    = (state_q == IDLE) ? (host_req_i ? EXEC : IDLE) :
                   (state_q == EXEC) ? ACK : (host_req_i ? WAIT_LOW : IDLE);
      op_d       = (state_q == IDLE && host_req_i) ? host_op_i : op_q;
      ch_d       = (state_q == IDLE && host_req_i) ? host_ch_i : ch_q;
      wdata_d    = (state_q == IDLE && host_req_i) ? host_wdata_i : wdata_q;
      ack_d      = exec;
      err_d      = exec && !ch_ok;
      rdata_d    = '0;
      force_en_d = force_en_q;
      chg        = '0;
      sel        = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         sel[c]         = exec && ch_ok && (ch_q == CH_W'(c));
         force_val_d[c] = (sel[c] && op_q == 2'b10) ? wdata_q : force_val_q[c];
         force_en_d[c]  = (sel[c] && op_q == 2'b10) ? 1'b1 :
                          (sel[c] && op_q == 2'b11) ? 1'b0 : force_en_q[c];
         obs_d[c]       = force_en_q[c] ? force_val_q[c] : dut_val_i[c*WIDTH +: WIDTH];
         chg[c]         = obs_d[c] != obs_q[c];
         cnt_d[c]       = (sel[c] && op_q == 2'b01) ? CNT_W'(chg[c]) :
                          (chg[c] && cnt_q[c] != '1) ? cnt_q[c] + 1'b1 : cnt_q[c];
         rdata_d        = !sel[c] ? rdata_d :
                          (op_q == 2'b00) ? CNT_W'(obs_q[c]) :
                          (op_q == 2'b01) ? cnt_q[c] : '0;
      end
   end
   // state registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         op_q       <= '0;
         ch_q       <= '0;
         wdata_q    <= '0;
         force_en_q <= '0;
         ack_q      <= 1'b0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         for (int c = 0; c < NUM_CH; c++) begin
            force_val_q[c] <= '0;
            obs_q[c]       <= '0;
            cnt_q[c]       <= '0;
         end
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         ch_q       <= ch_d;
         wdata_q    <= wdata_d;
         force_en_q <= force_en_d;
         ack_q      <= ack_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         for (int c = 0; c < NUM_CH; c++) begin
            force_val_q[c] <= force_val_d[c];
            obs_q[c]       <= obs_d[c];
            cnt_q[c]       <= cnt_d[c];
         end
      end
   end
endmodule

// File: tb/tb_obs_force_bank.sv
// tb_obs_force_bank: directed checks of force/release, counters, saturation, errors, handshake and reset abort
module tb_obs_force_bank;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  host_op = '0;
   logic [1:0]  host_ch = '0;
   logic [7:0]  host_wd = '0;
   logic        req_a = 1'b0, req_b = 1'b0, req_c = 1'b0;
   logic [31:0] dut_a = '0;
   logic [15:0] dut_b = '0;
   logic [23:0] dut_c = '0;
   logic [31:0] obs_a;
   logic [15:0] obs_b;
   logic [23:0] obs_c;
   logic [3:0]  fa_a, fa_b;
   logic [2:0]  fa_c;
   logic        ack_a, ack_b, ack_c, err_a, err_b, err_c;
   logic [15:0] rdata_a, rdata_c;
   logic [3:0]  rdata_b;
   int          n_cmp = 0;
   int          n_bad = 0;
   logic [15:0] rd;
   logic        er, aa;
   int          lat, acks, first;

   always #5 clk = ~clk;

   obs_force_bank #(.NUM_CH(4), .WIDTH(8), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .dut_val_i(dut_a), .obs_val_o(obs_a), .force_active_o(fa_a),
      .host_req_i(req_a), .host_op_i(host_op), .host_ch_i(host_ch), .host_wdata_i(host_wd),
      .host_ack_o(ack_a), .host_rdata_o(rdata_a), .host_err_o(err_a));
   obs_force_bank #(.NUM_CH(4), .WIDTH(4), .CNT_W(4)) u_b (
      .clk(clk), .rst(rst), .dut_val_i(dut_b), .obs_val_o(obs_b), .force_active_o(fa_b),
      .host_req_i(req_b), .host_op_i(host_op), .host_ch_i(host_ch), .host_wdata_i(host_wd[3:0]),
      .host_ack_o(ack_b), .host_rdata_o(rdata_b), .host_err_o(err_b));
   obs_force_bank #(.NUM_CH(3), .WIDTH(8), .CNT_W(16)) u_c (
      .clk(clk), .rst(rst), .dut_val_i(dut_c), .obs_val_o(obs_c), .force_active_o(fa_c),
      .host_req_i(req_c), .host_op_i(host_op), .host_ch_i(host_ch), .host_wdata_i(host_wd),
      .host_ack_o(ack_c), .host_rdata_o(rdata_c), .host_err_o(err_c));

   function automatic logic ack_of(input int w);
      return (w == 0) ? ack_a : (w == 1) ? ack_b : ack_c;
   endfunction

   function automatic logic [15:0] rdata_of(input int w);
      return (w == 0) ? rdata_a : (w == 1) ? {12'h000, rdata_b} : rdata_c;
   endfunction

   function automatic logic err_of(input int w);
      return (w == 0) ? err_a : (w == 1) ? err_b : err_c;
   endfunction

   task automatic set_req(input int w, input logic v);
      if (w == 0) req_a = v;
      else if (w == 1) req_b = v;
      else req_c = v;
   endtask

   // Called at a negedge; raises req, waits (bounded) for the ack, drops req, lets one more edge pass.
   task automatic host(input int w, input logic [1:0] op, input logic [1:0] ch, input logic [7:0] wd,
                       output logic [15:0] r, output logic e, output int l, output logic a_after);
      host_op = op; host_ch = ch; host_wd = wd;
      set_req(w, 1'b1);
      l = 99; r = '0; e = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clk); @(negedge clk);
         if (ack_of(w)) begin
            l = i; r = rdata_of(w); e = err_of(w);
            break;
         end
      end
      set_req(w, 1'b0);
      @(posedge clk); @(negedge clk);
      a_after = ack_of(w);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dut_a = 32'h1122_3344;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_cmp++; if (obs_a !== 32'h0) begin n_bad++; $display("FAIL reset_obs: got %h expected %h", obs_a, 32'h0); end
      n_cmp++; if (fa_a !== 4'h0) begin n_bad++; $display("FAIL reset_force: got %h expected %h", fa_a, 4'h0); end
      n_cmp++; if ({ack_a, err_a, rdata_a} !== 18'h0) begin n_bad++; $display("FAIL reset_host: got %h expected %h", {ack_a, err_a, rdata_a}, 18'h0); end
      rst = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (obs_a !== 32'h1122_3344) begin n_bad++; $display("FAIL latency_obs: got %h expected %h", obs_a, 32'h1122_3344); end
      dut_a = 32'h0000_3C00;
      @(posedge clk); @(negedge clk);
   endtask

   task automatic test_force_release();
      n_cmp++; if (obs_a[15:8] !== 8'h3C) begin n_bad++; $display("FAIL pre_force_obs: got %h expected %h", obs_a[15:8], 8'h3C); end
      host(0, 2'b10, 2'd1, 8'hA5, rd, er, lat, aa);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL force_latency: got %0d expected %0d", lat, 2); end
      n_cmp++; if ({er, rd} !== 17'h0) begin n_bad++; $display("FAIL force_rdata: got %h expected %h", {er, rd}, 17'h0); end
      n_cmp++; if (aa !== 1'b0) begin n_bad++; $display("FAIL force_ack_width: got %b expected %b", aa, 1'b0); end
      n_cmp++; if (obs_a !== 32'h0000_A500) begin n_bad++; $display("FAIL force_obs: got %h expected %h", obs_a, 32'h0000_A500); end
      n_cmp++; if (fa_a !== 4'b0010) begin n_bad++; $display("FAIL force_active: got %b expected %b", fa_a, 4'b0010); end
      host(0, 2'b00, 2'd1, 8'h00, rd, er, lat, aa);
      n_cmp++; if (rd !== 16'h00A5) begin n_bad++; $display("FAIL read_forced: got %h expected %h", rd, 16'h00A5); end
      host(0, 2'b11, 2'd1, 8'h00, rd, er, lat, aa);
      n_cmp++; if (rd !== 16'h0) begin n_bad++; $display("FAIL release_rdata: got %h expected %h", rd, 16'h0); end
      n_cmp++; if (obs_a[15:8] !== 8'h3C) begin n_bad++; $display("FAIL release_obs: got %h expected %h", obs_a[15:8], 8'h3C); end
      n_cmp++; if (fa_a !== 4'b0000) begin n_bad++; $display("FAIL release_active: got %b expected %b", fa_a, 4'b0000); end
   endtask

   task automatic test_counter();
      // ch0 changed 0->44 at reset release and 44->00 one edge later
      host(0, 2'b01, 2'd0, 8'h00, rd, er, lat, aa);
      n_cmp++; if (rd !== 16'd2) begin n_bad++; $display("FAIL cnt_initial: got %0d expected %0d", rd, 2); end
      for (int i = 0; i < 10; i++) begin
         dut_a[7:0] = (i % 2 == 0) ? 8'h01 : 8'h00;
         @(posedge clk); @(negedge clk);
      end
      host(0, 2'b01, 2'd0, 8'h00, rd, er, lat, aa);
      n_cmp++; if (rd !== 16'd10) begin n_bad++; $display("FAIL cnt_toggle: got %0d expected %0d", rd, 10); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL cnt_latency: got %0d expected %0d", lat, 2); end
      host(0, 2'b01, 2'd0, 8'h00, rd, er, lat, aa);
      n_cmp++; if (rd !== 16'd0) begin n_bad++; $display("FAIL cnt_cleared: got %0d expected %0d", rd, 0); end
   endtask

   task automatic test_saturation();
      for (int i = 0; i < 20; i++) begin
         dut_b[11:8] = (i % 2 == 0) ? 4'h5 : 4'h0;
         @(posedge clk); @(negedge clk);
      end
      host(1, 2'b01, 2'd2, 8'h00, rd, er, lat, aa);
      n_cmp++; if (rd !== 16'h000F) begin n_bad++; $display("FAIL sat_cnt: got %h expected %h", rd, 16'h000F); end
      host(1, 2'b01, 2'd2, 8'h00, rd, er, lat, aa);
      n_cmp++; if (rd !== 16'h0000) begin n_bad++; $display("FAIL sat_cleared: got %h expected %h", rd, 16'h0000); end
   endtask

   task automatic test_error();
      host(2, 2'b10, 2'd0, 8'h11, rd, er, lat, aa);
      n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL err_valid_ch: got %b expected %b", er, 1'b0); end
      n_cmp++; if (fa_c !== 3'b001) begin n_bad++; $display("FAIL err_pre_active: got %b expected %b", fa_c, 3'b001); end
      host(2, 2'b10, 2'd3, 8'h99, rd, er, lat, aa);
      n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL err_flag: got %b expected %b", er, 1'b1); end
      n_cmp++; if (rd !== 16'h0) begin n_bad++; $display("FAIL err_rdata: got %h expected %h", rd, 16'h0); end
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL err_latency: got %0d expected %0d", lat, 2); end
      n_cmp++; if (fa_c !== 3'b001) begin n_bad++; $display("FAIL err_active: got %b expected %b", fa_c, 3'b001); end
      n_cmp++; if (obs_c !== 24'h00_0011) begin n_bad++; $display("FAIL err_obs: got %h expected %h", obs_c, 24'h00_0011); end
      n_cmp++; if ({err_c, rdata_c} !== 17'h0) begin n_bad++; $display("FAIL err_idle_outputs: got %h expected %h", {err_c, rdata_c}, 17'h0); end
      host(2, 2'b00, 2'd3, 8'h00, rd, er, lat, aa);
      n_cmp++; if ({er, rd} !== {1'b1, 16'h0}) begin n_bad++; $display("FAIL err_read: got %h expected %h", {er, rd}, {1'b1, 16'h0}); end
   endtask

   task automatic test_handshake();
      host_op = 2'b00; host_ch = 2'd1; req_a = 1'b1;
      acks = 0; first = 0;
      for (int i = 1; i <= 6; i++) begin
         @(posedge clk); @(negedge clk);
         if (ack_a) begin acks++; if (first == 0) first = i; end
      end
      n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL hs_one_ack: got %0d expected %0d", acks, 1); end
      n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL hs_first_ack: got %0d expected %0d", first, 2); end
      req_a = 1'b0;
      @(posedge clk); @(negedge clk);
      host(0, 2'b00, 2'd1, 8'h00, rd, er, lat, aa);
      n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL hs_second_latency: got %0d expected %0d", lat, 2); end
      n_cmp++; if (rd !== 16'h003C) begin n_bad++; $display("FAIL hs_second_rdata: got %h expected %h", rd, 16'h003C); end
   endtask

   task automatic test_reset_abort();
      host_op = 2'b10; host_ch = 2'd2; host_wd = 8'h77; req_a = 1'b1;
      @(posedge clk); @(negedge clk);
      rst = 1'b1;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (ack_a !== 1'b0) begin n_bad++; $display("FAIL abort_ack: got %b expected %b", ack_a, 1'b0); end
      n_cmp++; if (fa_a !== 4'b0000) begin n_bad++; $display("FAIL abort_active: got %b expected %b", fa_a, 4'b0000); end
      rst = 1'b0;
      acks = 0; first = 0;
      for (int i = 1; i <= 4; i++) begin
         @(posedge clk); @(negedge clk);
         if (ack_a) begin acks++; if (first == 0) first = i; end
      end
      n_cmp++; if (first !== 2) begin n_bad++; $display("FAIL abort_reissue_ack: got %0d expected %0d", first, 2); end
      n_cmp++; if (acks !== 1) begin n_bad++; $display("FAIL abort_ack_count: got %0d expected %0d", acks, 1); end
      n_cmp++; if (fa_a !== 4'b0100) begin n_bad++; $display("FAIL abort_reissue_active: got %b expected %b", fa_a, 4'b0100); end
      req_a = 1'b0;
      @(posedge clk); @(negedge clk);
      n_cmp++; if (obs_a[23:16] !== 8'h77) begin n_bad++; $display("FAIL abort_reissue_obs: got %h expected %h", obs_a[23:16], 8'h77); end
   endtask

   initial begin
      test_reset();
      test_force_release();
      test_counter();
      test_saturation();
      test_error();
      test_handshake();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule

// File: doc/obs_force_bank.md
OBS_FORCE_BANK -- requirements
Module: obs_force_bank

Interface
REQ-001 Parameter NUM_CH, default 4, number of observed/forceable channels (1..16).
REQ-002 Parameter WIDTH, default 8, bits per channel.
REQ-003 Parameter CNT_W, default 16, change-counter and read-data width; CNT_W >= WIDTH SHALL hold.
REQ-004 Derived CH_W = max(1, clog2(NUM_CH)).
REQ-005 Clocking: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state changes on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 dut_val_i  input  NUM_CH*WIDTH  live channel values; channel c at bits [c*WIDTH +: WIDTH].
REQ-009 obs_val_o  output  NUM_CH*WIDTH  registered per-channel value: forced value or dut_val_i.
REQ-010 force_active_o  output  NUM_CH  bit c high while channel c is forced.
REQ-011 host_req_i  input  1  host request; held high until host_ack_o is seen.
REQ-012 host_op_i  input  2  00 read value, 01 read-and-clear change count, 10 force with wdata, 11 release force.
REQ-013 host_ch_i  input  CH_W  target channel.
REQ-014 host_wdata_i  input  WIDTH  force value for op 10.
REQ-015 host_ack_o  output  1  one-cycle completion pulse.
REQ-016 host_rdata_o  output  CNT_W  read result, valid only while host_ack_o is high.
REQ-017 host_err_o  output  1  high with host_ack_o when host_ch_i >= NUM_CH.

Function
REQ-018 Datapath: each edge, obs_val_o[c] <= force_en[c] ? force_val[c] : dut_val_i[c]; latency one cycle.
REQ-019 Change count: cnt[c] increments when the next obs_val_o[c] differs from its current value; saturates at all-ones, never wraps.
REQ-020 Host FSM states: IDLE, EXEC, ACK, WAIT_LOW.
REQ-021 IDLE -> EXEC on an edge with host_req_i=1; host_op_i, host_ch_i and host_wdata_i are latched on that edge.
REQ-022 EXEC -> ACK unconditionally: the operation executes on this edge, and host_ack_o=1 for exactly the following cycle (ack two cycles after the req sample).
REQ-023 ACK -> WAIT_LOW if host_req_i=1, else -> IDLE; WAIT_LOW -> IDLE when host_req_i=0.
REQ-024 Exactly one operation per host_req_i assertion; no back-to-back re-trigger without req low for at least one edge.
REQ-025 Op 00: host_rdata_o = obs_val_o[ch] as registered before the EXEC edge, zero-extended to CNT_W.
REQ-026 Op 01: host_rdata_o = cnt[ch] before the EXEC edge; cnt[ch] is cleared on the EXEC edge, or set to 1 if a change occurs on that same edge.
REQ-027 Op 10: force_val[ch] <= wdata and force_en[ch] <= 1 on the EXEC edge; obs_val_o[ch] shows wdata one edge later; host_rdata_o = 0.
REQ-028 Op 11: force_en[ch] <= 0 on the EXEC edge; force_val is retained; obs_val_o tracks dut_val_i from the next edge; host_rdata_o = 0.
REQ-029 A force or release that changes obs_val_o counts as a change.
REQ-030 Out-of-range channel: ack with host_err_o=1 and host_rdata_o=0; no state changes. host_err_o=0 on all other acks.
REQ-031 host_rdata_o and host_err_o are 0 whenever host_ack_o=0.
REQ-032 Input changes on host_* after the IDLE sample are ignored until the next IDLE.

Reset
REQ-033 rst=1 at an edge: FSM -> IDLE; all of force_en, force_val, cnt, obs_val_o, host_ack_o, host_rdata_o and host_err_o -> 0.
REQ-034 Reset mid-transaction aborts it with no ack and no side effect not yet committed. If host_req_i is high on the first edge after rst deasserts, it is sampled as a new request.

Verification
REQ-035 Force/release: dut ch1=0x3C; op10 ch1 wdata=0xA5 -> ack 2 cycles after sample, obs ch1=0xA5 next edge, force_active_o=0010; op11 -> obs ch1=0x3C one edge after EXEC.
REQ-036 Counter: toggle dut ch0 every cycle for 10 cycles, then op01 -> rdata=10; immediate second op01 with no activity -> rdata=0.
REQ-037 Saturation (CNT_W=4): 20 changes on ch2 -> op01 returns 0xF.
REQ-038 Error path (NUM_CH=3): op10 to ch3 -> ack with err=1, rdata=0, force_active_o unchanged.
REQ-039 Handshake: hold req high 6 cycles -> exactly one ack; drop req for 1 cycle then raise it -> second ack 2 cycles after the new sample.
REQ-040 Reset abort: assert rst on the EXEC edge of an op10 -> no ack and force_active_o=0; with req held, an op issues after reset release.
